// File: rtl/rr_arbiter_mux.sv
// Round-robin arbiter onto one registered valid/ready output stream.
// The grant is held for a whole packet; out_source tags each word with its origin.
module rr_arbiter_mux #(
    parameter  int Count      = 4,
    parameter  int Width      = 32,
    localparam int SourceBits = $clog2(Count)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [Count-1:0]      in_valid,
    input  logic [Width-1:0]      in_data [Count],
    input  logic [Count-1:0]      in_last,
    output logic [Count-1:0]      in_ready,
    output logic                  out_valid,
    output logic [Width-1:0]      out_data,
    output logic                  out_last,
    output logic [SourceBits-1:0] out_source,
    input  logic                  out_ready
);

    logic                  valid_q, valid_d;
    logic [Width-1:0]      data_q, data_d;
    logic                  last_q, last_d;
    logic [SourceBits-1:0] src_q, src_d;
    logic                  locked_q, locked_d;
    logic [SourceBits-1:0] lock_src_q, lock_src_d;
    logic [SourceBits-1:0] ptr_q, ptr_d;

    logic [Count-1:0]      grant;
    logic [Width-1:0]      sel_data;
    logic                  sel_last;
    logic [SourceBits-1:0] sel_src;
    logic                  can_load;
    logic                  in_xfer;

    // Scan from the farthest candidate down to ptr+1 so the nearest valid source wins.
    always_comb begin
        int idx;
        grant = '0;
        idx   = 0;
        if (locked_q) begin
            grant[lock_src_q] = 1'b1;
        end else begin
            for (int o = Count; o >= 1; o--) begin
                idx = int'(ptr_q) + o;
                if (idx >= Count) idx = idx - Count;
                if (in_valid[idx]) grant = Count'(1) << idx;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        sel_src  = '0;
        for (int i = 0; i < Count; i++) begin
            sel_data = sel_data | (in_data[i] & {Width{grant[i]}});
            sel_last = sel_last | (in_last[i] & grant[i]);
            sel_src  = sel_src  | (SourceBits'(i) & {SourceBits{grant[i]}});
        end
    end

    assign can_load = ~valid_q | out_ready;
    assign in_ready = grant & {Count{can_load & ~reset}};
    assign in_xfer  = |(in_valid & in_ready);

    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        last_d     = last_q;
        src_d      = src_q;
        locked_d   = locked_q;
        lock_src_d = lock_src_q;
        ptr_d      = ptr_q;
        if (in_xfer) begin
            valid_d = 1'b1;
            data_d  = sel_data;
            last_d  = sel_last;
            src_d   = sel_src;
            if (sel_last) begin
                locked_d = 1'b0;
                ptr_d    = sel_src;
            end else begin
                locked_d   = 1'b1;
                lock_src_d = sel_src;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
            src_q      <= '0;
            locked_q   <= 1'b0;
            lock_src_q <= '0;
            ptr_q      <= SourceBits'(Count - 1);
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            last_q     <= last_d;
            src_q      <= src_d;
            locked_q   <= locked_d;
            lock_src_q <= lock_src_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_last   = last_q;
    assign out_source = src_q;

endmodule

// File: tb/tb_rr_arbiter_mux.sv
// Scoreboard bench for rr_arbiter_mux (Count=4, Width=8): per-source word queues
// feed the inputs, expected output words are queued in arbitration order.
module tb_rr_arbiter_mux;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_valid;
    logic [7:0] in_data [4];
    logic [3:0] in_last;
    logic [3:0] in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic [1:0] out_source;
    logic       out_ready;

    rr_arbiter_mux #(.Count(4), .Width(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_source(out_source), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    logic [8:0]  srcq [4][$];
    logic [10:0] sb [$];
    logic [3:0]  hold;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  last_rdy, last_acc;
    logic        last_ovld, last_olast;
    logic [7:0]  last_odata;
    logic [1:0]  last_osrc;
    int          n;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pkt(int s, int len, logic [7:0] base);
        for (int k = 0; k < len; k++) srcq[s].push_back({k == len - 1, base + 8'(k)});
    endtask

    task automatic exp_pkt(int s, int len, logic [7:0] base);
        for (int k = 0; k < len; k++) sb.push_back({2'(s), k == len - 1, base + 8'(k)});
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            in_valid[i] = (srcq[i].size() > 0) && !hold[i];
            if (srcq[i].size() > 0) begin
                in_data[i] = srcq[i][0][7:0];
                in_last[i] = srcq[i][0][8];
            end else begin
                in_data[i] = 8'($urandom);
                in_last[i] = 1'($urandom);
            end
        end
    endtask

    function automatic bit all_empty();
        bit e = (sb.size() == 0);
        for (int i = 0; i < 4; i++) if (srcq[i].size() > 0) e = 0;
        return e;
    endfunction

    task automatic tick();
        logic [10:0] e;
        logic [8:0]  w;
        @(negedge clk);
        last_rdy   = in_ready;
        last_acc   = in_valid & in_ready;
        last_ovld  = out_valid;
        last_odata = out_data;
        last_olast = out_last;
        last_osrc  = out_source;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_extra_word", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_data", out_data, e[7:0]);
                check("out_last", out_last, e[8]);
                check("out_source", out_source, e[10:9]);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (last_acc[i]) w = srcq[i].pop_front();
        drive();
    endtask

    task automatic drain(output int cnt);
        cnt = 0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            cnt = k;
            if (all_empty()) break;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hold  = '0;
        for (int i = 0; i < 4; i++) srcq[i].delete();
        sb.delete();
        drive();
        tick();
        tick();
        check("rst_ready", last_rdy, 0);
        check("rst_out_valid", last_ovld, 0);
        check("rst_out_data", last_odata, 0);
        check("rst_out_last", last_olast, 0);
        check("rst_out_source", last_osrc, 0);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        hold      = '0;
        drive();
        do_reset();

        // single word from source 0
        pkt(0, 1, 8'hA5); exp_pkt(0, 1, 8'hA5);
        drive();
        tick();
        check("s1_ready", last_rdy, 4'b0001);
        drain(n);
        check("s1_latency", n, 1);

        // fairness: all valid, single-word packets
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < 4; s++) begin
                pkt(s, 1, 8'(8'h80 + 16 * s + r));
                exp_pkt(s, 1, 8'(8'h80 + 16 * s + r));
            end
        drive();
        drain(n);
        check("s2_throughput", n, 9);

        // move ptr to 1, then a 3-word packet from source 2 competes with 0 and 3
        pkt(1, 1, 8'h01); exp_pkt(1, 1, 8'h01);
        drive();
        drain(n);
        pkt(0, 1, 8'h3F); pkt(2, 3, 8'h30); pkt(3, 1, 8'h38);
        exp_pkt(2, 3, 8'h30); exp_pkt(3, 1, 8'h38); exp_pkt(0, 1, 8'h3F);
        drive();
        drain(n);
        check("s3_cycles", n, 6);

        // locked source 1 drops valid for two cycles while source 0 waits
        pkt(1, 3, 8'h10); pkt(0, 1, 8'h20);
        exp_pkt(1, 3, 8'h10); exp_pkt(0, 1, 8'h20);
        drive();
        tick();
        check("s4_first_ready", last_rdy, 4'b0010);
        hold[1] = 1'b1;
        drive();
        for (int c = 0; c < 2; c++) begin
            tick();
            check("s4_src0_ready", last_rdy[0], 0);
            check("s4_no_xfer", last_acc, 0);
        end
        hold[1] = 1'b0;
        drive();
        drain(n);

        // backpressure with 8'h3C held in the output register
        pkt(2, 1, 8'h3C); pkt(3, 1, 8'h40);
        exp_pkt(2, 1, 8'h3C); exp_pkt(3, 1, 8'h40);
        drive();
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("s5_hold_data", last_odata, 8'h3C);
            check("s5_hold_valid", last_ovld, 1);
            check("s5_hold_ready", last_rdy, 0);
        end
        out_ready = 1'b1;
        tick();
        tick();
        check("s5_next_valid", last_ovld, 1);
        check("s5_sb_empty", sb.size(), 0);

        // reset during a locked packet from source 3
        pkt(3, 3, 8'h50);
        drive();
        tick();
        check("s6_lock_ready", last_rdy, 4'b1000);
        reset = 1'b1;
        tick();
        check("s6_rst_ready", last_rdy, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) srcq[i].delete();
        sb.delete();
        pkt(0, 1, 8'h60); pkt(3, 1, 8'h70);
        exp_pkt(0, 1, 8'h60); exp_pkt(3, 1, 8'h70);
        drive();
        tick();
        check("s6_post_valid", last_ovld, 0);
        check("s6_post_ready", last_rdy, 4'b0001);
        drain(n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
